// File: rtl/uart_pkg.sv
// Shared UART register map, LSR bit positions and the feeder state encoding.
package uart_pkg;

    // 16550-style register indices (0..7)
    localparam logic [2:0] REG_THR = 3'd0;
    localparam logic [2:0] REG_DLL = 3'd0;
    localparam logic [2:0] REG_DLM = 3'd1;
    localparam logic [2:0] REG_LCR = 3'd3;
    localparam logic [2:0] REG_LSR = 3'd5;

    // Transmit-holding-register-empty flag inside LSR
    localparam int LSR_THRE = 5;

    // Divisor-latch access bit inside LCR
    localparam logic [7:0] DLAB_MASK = 8'h80;

    typedef enum logic [2:0] {
        INIT_LCR_DLAB,
        INIT_DLL,
        INIT_DLM,
        INIT_LCR,
        IDLE,
        POLL_LSR,
        WRITE_THR
    } feeder_state_e;

    // Byte lane of a register inside its 32-bit word
    function automatic logic [3:0] reg_strb(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    // Word offset of a register: registers 4..7 live in the second word
    function automatic logic [31:0] reg_offset(input logic bank);
        return {29'd0, bank, 2'b00};
    endfunction

endpackage

// File: rtl/uart_apb_xfer.sv
// Single APB access engine: one SETUP cycle, then ACCESS until pready.
// A new start is taken in the completion cycle so accesses can run back to back.
module uart_apb_xfer
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  idx,
    input  logic        write,
    input  logic [7:0]  wbyte,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        slverr,
    output logic        psel,
    output logic        penable,
    output logic [31:0] paddr,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic        pready,
    input  logic [31:0] prdata,
    input  logic        pslverr
);

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_ACCESS = 2'd2;

    logic [1:0]  phase_reg;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic [3:0]  strb_reg;
    logic        write_reg;
    logic        unused_prdata;

    assign done   = (phase_reg == PH_ACCESS) && pready;
    assign busy   = (phase_reg != PH_IDLE) && !done;
    assign rdata  = prdata[7:0];
    assign slverr = pslverr;
    assign unused_prdata = ^prdata[31:8];

    // Phase sequencing; address/data registers are zero whenever the bus is idle
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_reg <= PH_IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            strb_reg  <= '0;
            write_reg <= 1'b0;
        end else if (start && !busy) begin
            phase_reg <= PH_SETUP;
            addr_reg  <= BASE_ADDR + reg_offset(idx[2]);
            data_reg  <= {4{wbyte}};
            strb_reg  <= reg_strb(idx[1:0]);
            write_reg <= write;
        end else if (phase_reg == PH_SETUP) begin
            phase_reg <= PH_ACCESS;
        end else if (done) begin
            phase_reg <= PH_IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            strb_reg  <= '0;
            write_reg <= 1'b0;
        end
    end

    assign psel    = (phase_reg != PH_IDLE);
    assign penable = (phase_reg == PH_ACCESS);
    assign paddr   = addr_reg;
    assign pwrite  = write_reg;
    assign pwdata  = data_reg;
    assign pstrb   = strb_reg;

endmodule

// File: rtl/uart_apb_feeder.sv
// Programs a 16550-style UART over APB, then streams accepted bytes into THR,
// polling LSR.THRE only when the local FIFO credit is exhausted.
module uart_apb_feeder
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [15:0] DIVISOR    = 16'd1,
    parameter logic [7:0]  LCR_VAL    = 8'h03,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic [31:0] out_paddr,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr,
    output logic        init_done,
    output logic        err
);

    localparam int CREDIT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(FIFO_DEPTH);

    feeder_state_e       state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [7:0]          hold_reg, hold_next;
    logic                init_done_reg, init_done_next;
    logic                err_reg, err_next;

    logic       xfer_start;
    logic       xfer_busy;
    logic       xfer_done;
    logic       xfer_slverr;
    logic [7:0] xfer_rdata;
    logic [2:0] req_idx;
    logic       req_write;
    logic [7:0] req_byte;
    logic       unused_rdata;

    assign in_ready     = (state_reg == IDLE) && init_done_reg;
    assign init_done    = init_done_reg;
    assign err          = err_reg;
    assign out_pprot    = 3'b000;
    assign unused_rdata = ^{xfer_rdata[7:6], xfer_rdata[4:0]};

    // Sequencing: init writes, byte accept, THRE polling and credit bookkeeping
    always_comb begin
        state_next     = state_reg;
        credit_next    = credit_reg;
        hold_next      = hold_reg;
        init_done_next = init_done_reg;
        err_next       = err_reg | (xfer_done & xfer_slverr);
        case (state_reg)
            INIT_LCR_DLAB: if (xfer_done) state_next = INIT_DLL;
            INIT_DLL:      if (xfer_done) state_next = INIT_DLM;
            INIT_DLM:      if (xfer_done) state_next = INIT_LCR;
            INIT_LCR: begin
                if (xfer_done) begin
                    state_next     = IDLE;
                    init_done_next = 1'b1;
                end
            end
            IDLE: begin
                if (in_valid && in_ready) begin
                    hold_next  = in_data;
                    state_next = (credit_reg != '0) ? WRITE_THR : POLL_LSR;
                end
            end
            POLL_LSR: begin
                // A failed LSR read is treated as "not empty" and simply repolled
                if (xfer_done && !xfer_slverr && xfer_rdata[LSR_THRE]) begin
                    credit_next = CREDIT_MAX;
                    state_next  = WRITE_THR;
                end
            end
            WRITE_THR: begin
                // Credit is spent even if the write errored; the byte is lost
                if (xfer_done) begin
                    credit_next = (credit_reg == '0) ? '0 : credit_reg - 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = INIT_LCR_DLAB;
        endcase
    end

    // Access request for the state being entered, so the engine restarts without a gap
    always_comb begin
        req_idx   = REG_THR;
        req_write = 1'b0;
        req_byte  = 8'h00;
        case (state_next)
            INIT_LCR_DLAB: begin req_idx = REG_LCR; req_write = 1'b1; req_byte = LCR_VAL | DLAB_MASK; end
            INIT_DLL:      begin req_idx = REG_DLL; req_write = 1'b1; req_byte = DIVISOR[7:0];       end
            INIT_DLM:      begin req_idx = REG_DLM; req_write = 1'b1; req_byte = DIVISOR[15:8];      end
            INIT_LCR:      begin req_idx = REG_LCR; req_write = 1'b1; req_byte = LCR_VAL;            end
            POLL_LSR:      begin req_idx = REG_LSR; req_write = 1'b0; req_byte = 8'h00;              end
            WRITE_THR:     begin req_idx = REG_THR; req_write = 1'b1; req_byte = hold_next;          end
            default:       begin req_idx = REG_THR; req_write = 1'b0; req_byte = 8'h00;              end
        endcase
        xfer_start = !xfer_busy && (state_next != IDLE);
    end

    // State, credit, holding byte and status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= INIT_LCR_DLAB;
            credit_reg    <= '0;
            hold_reg      <= 8'h00;
            init_done_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            credit_reg    <= credit_next;
            hold_reg      <= hold_next;
            init_done_reg <= init_done_next;
            err_reg       <= err_next;
        end
    end

    uart_apb_xfer #(
        .BASE_ADDR (BASE_ADDR)
    ) u_xfer (
        .clock   (clock),
        .reset   (reset),
        .start   (xfer_start),
        .idx     (req_idx),
        .write   (req_write),
        .wbyte   (req_byte),
        .busy    (xfer_busy),
        .done    (xfer_done),
        .rdata   (xfer_rdata),
        .slverr  (xfer_slverr),
        .psel    (out_psel),
        .penable (out_penable),
        .paddr   (out_paddr),
        .pwrite  (out_pwrite),
        .pwdata  (out_pwdata),
        .pstrb   (out_pstrb),
        .pready  (out_pready),
        .prdata  (out_prdata),
        .pslverr (out_pslverr)
    );

endmodule

// File: doc/uart_apb_feeder.md
UART_APB_FEEDER -- requirements
Module: uart_apb_feeder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, meaning APB base address of the UART register block.
REQ-002 SHALL have parameter DIVISOR, default 16'd1, meaning baud divisor written to DLM:DLL.
REQ-003 SHALL have parameter LCR_VAL, default 8'h03, meaning line control value (8N1).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, meaning THR bytes writable per observed THRE.
REQ-005 Ports: clock in 1, sole clock; reset in 1, synchronous active-high; one clock, synchronous active-high reset, no other clock or reset.
REQ-006 Ports: in_valid in 1 byte offered; in_ready out 1 byte accepted; in_data in 8 byte.
REQ-007 Ports: out_psel out 1; out_penable out 1; out_pprot out 3 (always 3'b000); out_paddr out 32; out_pwrite out 1; out_pwdata out 32; out_pstrb out 4.
REQ-008 Ports: out_pready in 1; out_prdata in 32; out_pslverr in 1.
REQ-009 Ports: init_done out 1 (init sequence complete); err out 1 (sticky, any pslverr seen).

Function
REQ-010 Register k (0..7) SHALL be accessed with paddr = BASE_ADDR + {k[2],2'b00}, pstrb = 4'b0001 << k[1:0], pwdata = {4{byte}}; this applies to reads as well as writes.
REQ-011 Every access SHALL be a SETUP cycle (psel=1, penable=0), then ACCESS cycles (psel=1, penable=1) until pready=1; addr/write/data/strb held constant across both phases.
REQ-012 Read data SHALL be sampled as prdata[7:0] in the ACCESS cycle where pready=1.
REQ-013 Idle bus SHALL drive psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0.
REQ-014 FSM states: INIT_LCR_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, IDLE, POLL_LSR, WRITE_THR.
REQ-015 Init writes, in order: reg3=LCR_VAL|8'h80, reg0=DIVISOR[7:0], reg1=DIVISOR[15:8], reg3=LCR_VAL; then IDLE and init_done=1 (stays 1 until reset).
REQ-016 in_ready SHALL be 1 only in IDLE with init_done=1; on in_valid&in_ready, in_data is latched into a holding register.
REQ-017 After accept: credit>0 -> WRITE_THR (reg0 = held byte), credit decrements on completion; credit=0 -> POLL_LSR (read reg5).
REQ-018 POLL_LSR completion: LSR[5]=1 -> credit=FIFO_DEPTH, go WRITE_THR; LSR[5]=0 -> issue another POLL_LSR immediately (next cycle SETUP).
REQ-019 WRITE_THR completion -> IDLE; throughput with credit>0 is one byte per 3 cycles at zero wait states.
REQ-020 Credit counter width clog2(FIFO_DEPTH+1); SHALL saturate, never wrap below 0 or above FIFO_DEPTH.
REQ-021 pslverr=1 at completion SHALL set err and count as completion; a failed LSR read counts as THRE=0; a failed THR write still consumes credit and drops the byte.
REQ-022 in_data changes while not in IDLE SHALL have no effect on the held byte.

Reset
REQ-023 Reset SHALL force INIT_LCR_DLAB (SETUP not yet issued), credit=0, init_done=0, err=0, in_ready=0, bus outputs as REQ-013, holding register 0.
REQ-024 Reset mid-access SHALL abandon the transfer at the next edge; first post-reset cycle drives idle bus, SETUP of init write begins the cycle after.

Structure
REQ-025 Shared package uart_pkg SHALL hold UART register offsets (THR/DLL=0, DLM=1, LCR=3, LSR=5), LSR_THRE bit index 5, DLAB mask 8'h80, and the FSM state enum.
REQ-026 One sub-module uart_apb_xfer SHALL implement a single APB access (start, addr index, write, byte -> done, rdata, slverr); the FSM/credit logic sits in uart_apb_feeder.

Verification
REQ-027 Reset release, pready tied 1, DIVISOR=16'h0102 -> writes (paddr 0x1000_0000, strb 1000, 0x83), (..0000, 0001, 0x02), (..0000, 0010, 0x01), (..0000, 1000, 0x03); init_done=1 at cycle 9.
REQ-028 Send 0x41, LSR returns 0x60 -> one read (paddr 0x1000_0004, strb 0010), then write paddr 0x1000_0000 strb 0001 pwdata 0x4141_4141.
REQ-029 LSR returns 0x00 three times then 0x20 -> exactly four polls, then one THR write; in_ready low throughout.
REQ-030 17 back-to-back bytes, LSR 0x20 -> poll, 16 writes without poll, poll, 17th write.
REQ-031 pready held 0 for 5 ACCESS cycles on THR write -> signals stable for all 6 ACCESS cycles; pslverr=1 on completion -> err=1 stays set.
REQ-032 Reset asserted during a poll ACCESS -> next cycle idle bus, init_done=0, credit=0, init sequence restarts.
